// File: rtl/data_memory_pipe_if.sv
// Request/response bus between the LSU/MEM stage and data_memory_pipe.
// The master modport is the LSU side and the slave modport is the memory side.
interface data_memory_pipe_if;
    logic        req_valid;
    logic        req_ready;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] DataRd;
    logic        rsp_fault;

    modport master (
        output req_valid, DMWr, DMCtrl, Address, DataWr, rsp_ready,
        input  req_ready, rsp_valid, DataRd, rsp_fault
    );

    modport slave (
        input  req_valid, DMWr, DMCtrl, Address, DataWr, rsp_ready,
        output req_ready, rsp_valid, DataRd, rsp_fault
    );
endinterface

// File: rtl/data_memory_pipe.sv
// Handshaked RV32 data memory: byte-lane stores, registered loads, fault reporting.
// Optional DMEM_CLEAR_EN zeroes the whole array after reset before accepting requests.
module data_memory_pipe #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_pipe_if.slave bus
);
    localparam int             AW      = $clog2(DEPTH_WORDS);
    localparam logic [30:0]    DEPTH_W = 31'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;

    logic [30:0]   word_diff;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_byte, is_half, is_word, legal, misaligned, fault;
    logic [3:0]    byte_we;
    logic [31:0]   wr_data;
    logic          core_ready, accept, wr_en;

    logic          rsp_valid, rsp_fault, rsp_load;
    logic [2:0]    rsp_ctrl;
    logic [1:0]    rsp_lane;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   rd_data;

    // A borrow out of the subtraction lands in bit 30, so one compare covers both range ends.
    assign word_diff = {1'b0, bus.Address[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign idx       = word_diff[AW-1:0];
    assign lane      = bus.Address[1:0];

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        legal   = 1'b0;
        case (bus.DMCtrl)
            3'b000:         begin is_word = 1'b1; legal = 1'b1; end
            3'b001:         begin is_byte = 1'b1; legal = 1'b1; end
            3'b010:         begin is_half = 1'b1; legal = 1'b1; end
            3'b100:         begin is_byte = 1'b1; legal = !bus.DMWr; end
            3'b101:         begin is_half = 1'b1; legal = !bus.DMWr; end
            default:        legal = 1'b0;
        endcase
        misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
        fault      = (word_diff >= DEPTH_W) || misaligned || !legal;

        byte_we = 4'b0000;
        wr_data = bus.DataWr;
        if (is_word) begin
            byte_we = 4'b1111;
        end else if (is_half) begin
            byte_we = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.DataWr[15:0]}};
        end else if (is_byte) begin
            byte_we = 4'b0001 << lane;
            wr_data = {4{bus.DataWr[7:0]}};
        end
    end

`ifdef DMEM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    state_t        state, state_next;
    logic [AW-1:0] clear_cnt;
    logic          clear_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clear_cnt <= clear_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        core_ready = 1'b0;
        clear_we   = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (clear_cnt == LAST_IDX)
                    state_next = READY;
            end
            READY:   core_ready = 1'b1;
            default: state_next = CLEAR;
        endcase
    end
`else
    assign core_ready = 1'b1;
`endif

    assign bus.req_ready = core_ready && (!rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_en         = accept && bus.DMWr && !fault;

    // The sweep and normal stores never overlap because req_ready is low while clearing.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (clear_we)
            mem[clear_cnt] <= '0;
`endif
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (byte_we[b])
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        if (accept && !bus.DMWr && !fault)
            rd_word <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_load  <= 1'b0;
            rsp_ctrl  <= 3'b000;
            rsp_lane  <= 2'b00;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
            rsp_load  <= !bus.DMWr && !fault;
            rsp_ctrl  <= bus.DMCtrl;
            rsp_lane  <= lane;
        end else if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_load  <= 1'b0;
        end
    end

    // rd_word is never reset, so rsp_load gates it to keep DataRd at zero otherwise.
    always_comb begin
        case (rsp_lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = rsp_lane[1] ? rd_word[31:16] : rd_word[15:0];
        rd_data  = '0;
        if (rsp_load) begin
            case (rsp_ctrl)
                3'b001:  rd_data = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  rd_data = {24'h0, byte_sel};
                3'b010:  rd_data = {{16{half_sel[15]}}, half_sel};
                3'b101:  rd_data = {16'h0, half_sel};
                default: rd_data = rd_word;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_fault = rsp_fault;
    assign bus.DataRd    = rd_data;
endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed scoreboard bench for data_memory_pipe (16 words at base 0).
// Expected responses are queued on acceptance and popped when the DUT hands them over.
module tb_data_memory_pipe;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    data_memory_pipe_if dif ();

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   waited;
    int   cnt;

    data_memory_pipe #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Holds the request until accepted (bounded) and queues the expected response.
    task automatic applyStimulus(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input logic exp_fault, input string tag, output int wait_cycles);
        logic rdy;
        logic accepted;
        exp_t e;
        dif.req_valid = 1'b1;
        dif.DMWr      = wr;
        dif.DMCtrl    = ctrl;
        dif.Address   = addr;
        dif.DataWr    = wdata;
        wait_cycles   = 0;
        accepted      = 1'b0;
        while (!accepted && wait_cycles < 100) begin
            @(negedge clk);
            rdy = dif.req_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
            else     wait_cycles++;
        end
        dif.req_valid = 1'b0;
        if (accepted) begin
            e.data  = exp_data;
            e.fault = exp_fault;
            e.tag   = tag;
            sb.push_back(e);
        end else begin
            checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic countClearCycles(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (dif.req_ready) break;
            n++;
        end
    endtask

    // Response monitor: compares every handed-over response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && dif.rsp_valid && dif.rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.tag, "_data"}, dif.DataRd, e.data);
                checkOutput({e.tag, "_fault"}, {31'd0, dif.rsp_fault}, {31'd0, e.fault});
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        dif.req_valid = 1'b0;
        dif.DMWr      = 1'b0;
        dif.DMCtrl    = 3'b000;
        dif.Address   = 32'h0;
        dif.DataWr    = 32'h0;
        dif.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", {31'd0, dif.rsp_valid}, 32'd0);
        checkOutput("reset_DataRd", dif.DataRd, 32'd0);
        checkOutput("reset_rsp_fault", {31'd0, dif.rsp_fault}, 32'd0);
`ifdef DMEM_CLEAR_EN
        checkOutput("reset_req_ready", {31'd0, dif.req_ready}, 32'd0);
`else
        checkOutput("reset_req_ready", {31'd0, dif.req_ready}, 32'd1);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
        $display("[TB] clear sweep after reset");
        countClearCycles(cnt);
        checkOutput("clear_cycles", cnt, DEPTH);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b000, 32'h00, 32'h0, 32'h0, 1'b0, "clear_w0", waited);
        applyStimulus(1'b0, 3'b000, 32'h3C, 32'h0, 32'h0, 1'b0, "clear_w15", waited);
        applyStimulus(1'b1, 3'b000, 32'h28, 32'h12345678, 32'h0, 1'b0, "pre_st_w10", waited);
        applyStimulus(1'b1, 3'b000, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0, "pre_st_w0", waited);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midclear_req_ready", {31'd0, dif.req_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        countClearCycles(cnt);
        checkOutput("restart_clear_cycles", cnt, DEPTH);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b000, 32'h00, 32'h0, 32'h0, 1'b0, "reclear_w0", waited);
        applyStimulus(1'b0, 3'b000, 32'h28, 32'h0, 32'h0, 1'b0, "reclear_w10", waited);
`endif

        $display("[TB] word store then load");
        applyStimulus(1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_word", waited);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_word_raw", waited);
        checkOutput("raw_b2b_wait", waited, 0);

        $display("[TB] byte store and loads");
        applyStimulus(1'b1, 3'b000, 32'h10, 32'h11223344, 32'h0, 1'b0, "st_base", waited);
        applyStimulus(1'b1, 3'b001, 32'h13, 32'h00000080, 32'h0, 1'b0, "st_byte", waited);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 32'h80223344, 1'b0, "ld_word_b", waited);
        applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "ld_lb", waited);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "ld_lbu", waited);

        $display("[TB] half store and loads");
        applyStimulus(1'b1, 3'b000, 32'h10, 32'h00000000, 32'h0, 1'b0, "st_zero", waited);
        applyStimulus(1'b1, 3'b010, 32'h12, 32'h0000ABCD, 32'h0, 1'b0, "st_half", waited);
        applyStimulus(1'b0, 3'b010, 32'h12, 32'h0, 32'hFFFFABCD, 1'b0, "ld_lh", waited);
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000ABCD, 1'b0, "ld_lhu", waited);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 32'hABCD0000, 1'b0, "ld_word_h", waited);

        $display("[TB] faults");
        applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, "flt_lh_mis", waited);
        applyStimulus(1'b1, 3'b000, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, "flt_sw_mis", waited);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 32'hABCD0000, 1'b0, "reread_1", waited);
        applyStimulus(1'b0, 3'b000, BASE + DEPTH * 4, 32'h0, 32'h0, 1'b1, "flt_range", waited);
        applyStimulus(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, "flt_st_ctrl", waited);
        applyStimulus(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, "flt_ld_ctrl", waited);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 32'hABCD0000, 1'b0, "reread_2", waited);

        $display("[TB] backpressure");
        @(posedge clk);
        #1 dif.rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 32'hABCD0000, 1'b0, "ld_held", waited);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("held_rsp_valid", {31'd0, dif.rsp_valid}, 32'd1);
            checkOutput("held_DataRd", dif.DataRd, 32'hABCD0000);
            checkOutput("held_req_ready", {31'd0, dif.req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        dif.rsp_ready = 1'b1;
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000ABCD, 1'b0, "b2b_lhu", waited);
        checkOutput("b2b_wait_1", waited, 0);
        applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, "b2b_lb", waited);
        checkOutput("b2b_wait_2", waited, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised, handshaked successor to the single-cycle data memory of the RV32 core.
- Byte-lane-correct sub-word loads and stores, selected by Address[1:0].
- Registered one-cycle read with response backpressure.
- Misalignment and out-of-range fault reporting.
- Sits between the LSU/MEM stage and on-chip SRAM, for the pipelined core.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words (power of two, >=4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
DMWr  input  1  1 = store, 0 = load
DMCtrl  input  3  000 word, 001 byte signed, 010 half signed, 100 byte unsigned, 101 half unsigned
Address  input  32  byte address
DataWr  input  32  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
DataRd  output  32  load data, extended per DMCtrl; 0 for stores and faults
rsp_fault  output  1  access faulted, no memory side effect

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values: rsp_valid=0, DataRd=0, rsp_fault=0, and the internal response-side copy of DMCtrl/byte offset =0.
- req_ready with the feature off: 1 in reset and after reset.
- Memory array is not reset.
- Handshake: req_ready = !rsp_valid || rsp_ready (one-entry pipeline). Holding occupancy stays combinational from the response register.
- Latency: request accepted at edge N. rsp_valid rises after edge N and holds until rsp_ready is seen at an edge.
- Back-to-back requests with rsp_ready=1 give one response per cycle.
- While rsp_valid && !rsp_ready: DataRd, rsp_fault and rsp_valid are stable, and no request is accepted.
- Word index = (Address - BASE_ADDR)[31:2]. Lane = Address[1:0].
- Fault conditions (set rsp_fault=1, DataRd=0, no write):
  - out of range: Address < BASE_ADDR or index >= DEPTH_WORDS;
  - misaligned: half with Address[0]=1, or word with Address[1:0]!=0;
  - illegal DMCtrl: load with 011/110/111, store with any code other than 000/001/010.
- Store:
  - Commits at the acceptance edge using per-byte write enables.
  - byte: lane Address[1:0] <= DataWr[7:0].
  - half: lanes {A[1],0} and {A[1],1} <= DataWr[15:0].
  - word: all four lanes.
  - Other bytes are untouched.
- Load:
  - Array read at the acceptance edge into a 32-bit register. Lane extraction and extension are applied from the registered offset/DMCtrl.
  - byte: selected lane, sign bit 7 (001) or zero (100).
  - half: lanes {A[1],1}:{A[1],0}, sign bit 15 (010) or zero (101).
- Read-after-write: a store accepted at edge N followed by a load of the same word at edge N+1 returns the stored data. The array write precedes the read.
- Reset mid-operation: pending response is dropped, rsp_valid=0. Stores already committed remain in memory.

Optional Feature:
Macro DMEM_CLEAR_EN.

With DMEM_CLEAR_EN defined, a two-state FSM runs:
- CLEAR: entered on reset. A counter 0..DEPTH_WORDS-1 writes 32'h0 to one word per cycle; req_ready=0.
- Transition to READY after the last word is written.
- READY: normal operation.
- Clear takes exactly DEPTH_WORDS cycles after rst_n deasserts. The first request can be accepted at edge DEPTH_WORDS+1.
- Reset during CLEAR restarts the sweep from 0.

Without DMEM_CLEAR_EN:
- No FSM; READY is implied and req_ready follows the handshake rule from the first edge after reset.
- Memory contents are undefined until written.

Test Plan:
1. Store word 32'hDEADBEEF @0x10, then load word @0x10 -> rsp_valid next cycle, DataRd=32'hDEADBEEF, rsp_fault=0.
2. Byte store 32'h00000080 @0x13 onto word 0x11223344, then loads @0x10:
   - word -> 32'h80223344;
   - byte signed @0x13 -> 32'hFFFFFF80;
   - byte unsigned @0x13 -> 32'h00000080.
3. Half store 32'h0000ABCD @0x12 on word 0, then loads:
   - half signed @0x12 -> 32'hFFFFABCD;
   - half unsigned -> 32'h0000ABCD;
   - word @0x10 -> 32'hABCD0000.
4. Faults, each giving rsp_fault=1 and DataRd=0, with memory unchanged on re-read:
   - half load @0x11;
   - word store @0x12;
   - load @BASE_ADDR+DEPTH_WORDS*4;
   - store with DMCtrl=100.
5. Backpressure: rsp_ready=0 for 3 cycles after a load -> rsp_valid/DataRd stable, req_ready=0. Then rsp_ready=1 for 2 cycles with back-to-back requests -> one response per cycle.
6. DMEM_CLEAR_EN with DEPTH_WORDS=16:
   - req_ready=0 for 16 cycles after reset, then any word reads 0;
   - reset asserted at cycle 5 of the sweep -> sweep restarts and takes a full 16 cycles.
